// File: rtl/ula_pkg.sv
// Shared constants for the ULA arbiter: opcodes, FSM encoding, default ALU latency.
package ula_pkg;

  localparam int         ALU_LAT_DEF = 2;
  localparam logic [2:0] OP_SOMA     = 3'b000;
  localparam logic [2:0] OP_SUB      = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_valido(input logic [2:0] op);
    return (op == OP_SOMA) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin arbiter; one-hot grant, pointer advances only on a grant.
module arb_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // index of the requester granted last; reset to 1 so requester 0 wins first
  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end

endmodule

// File: rtl/ula_arbitro.sv
// Two requesters sharing one pipelined ALU, one operation in flight.
// Optional opcode filtering with ULA_ARBITRO_OPCHECK_EN.
module ula_arbitro
  import ula_pkg::*;
#(
  parameter int ALU_LAT = ALU_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [5:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_s,
  input  logic        alu_flag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_s,
  output logic        rsp_flag,
  output logic        rsp_err
);

  localparam int NUM_REQ = 2;
  localparam int CW      = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(ALU_LAT);

  state_t state, state_d;
  logic [NUM_REQ-1:0][2:0] op_v;
  logic [NUM_REQ-1:0][7:0] a_v, b_v;
  logic [1:0]    gnt;
  logic          gid, take, op_bad, exec_done, arb_en;
  logic [CW-1:0] cnt;

  assign op_v = req_op;
  assign a_v  = req_a;
  assign b_v  = req_b;

  // reset also masks the combinational grant so req_ready drops immediately
  assign arb_en = (state == IDLE) && rst_n;

  arb_rr2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   (req_valid),
    .gnt   (gnt)
  );

  assign req_ready = gnt;
  assign take      = |gnt;
  assign gid       = gnt[1];
  assign exec_done = (state == EXEC) && (cnt == CNT_MAX);
  assign rsp_valid = (state == RESP);

`ifdef ULA_ARBITRO_OPCHECK_EN
  assign op_bad = !op_valido(op_v[gid]);
`else
  assign op_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (take) state_d = op_bad ? RESP : EXEC;
      EXEC:    if (exec_done) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      rsp_id   <= 1'b0;
      rsp_s    <= '0;
      rsp_flag <= 1'b0;
    end else begin
      if (take) begin
        cnt    <= '0;
        rsp_id <= gid;
        if (op_bad) begin
          rsp_s    <= '0;
          rsp_flag <= 1'b0;
        end else begin
          alu_a  <= a_v[gid];
          alu_b  <= b_v[gid];
          alu_op <= op_v[gid];
        end
      end else if (state == EXEC) begin
        cnt <= cnt + 1'b1;
      end
      if (exec_done) begin
        rsp_s    <= alu_s;
        rsp_flag <= alu_flag;
      end
    end
  end

`ifdef ULA_ARBITRO_OPCHECK_EN
  logic rsp_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rsp_err_q <= 1'b0;
    else if (take)             rsp_err_q <= op_bad;
    else if (exec_done)        rsp_err_q <= 1'b0;
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ula_arbitro.sv
// Directed bench for ula_arbitro with a two-stage ALU model behind the alu_* ports.
module tb_ula_arbitro;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready;
  logic [5:0]  req_op;
  logic [15:0] req_a, req_b;
  logic [7:0]  alu_a, alu_b, alu_s;
  logic [2:0]  alu_op;
  logic        alu_flag;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_flag, rsp_err;
  logic [7:0]  rsp_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ula_arbitro #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_s(alu_s), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_flag(rsp_flag), .rsp_err(rsp_err)
  );

  // ALU model: add with carry, subtract with borrow, xor for anything else
  logic [8:0] p1, p2;
  always_ff @(posedge clk) begin
    case (alu_op)
      3'b000:  p1 <= {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  p1 <= {1'b0, alu_a} - {1'b0, alu_b};
      default: p1 <= {1'b0, alu_a ^ alu_b};
    endcase
    p2 <= p1;
  end
  assign {alu_flag, alu_s} = p2;

`ifdef ULA_ARBITRO_OPCHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    step(); step();
    rst_n = 1'b1; #1;
  endtask

  task automatic drain();
    int c = 0;
    req_valid = 2'b00; rsp_ready = 1'b1;
    while (!rsp_valid && c < 20) begin step(); c++; end
    n_vec++;
    if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL drain: rsp_valid never rose"); end
    step(); rsp_ready = 1'b0; #1;
  endtask

  // one full operation with idle response side; lat = cycles from grant to rsp_valid
  task automatic do_op(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic ef, input logic chk_f, input logic ee,
                       input int lat, input string nm);
    logic [1:0] er;
    logic       id;
    er = 2'b01 << idx;
    id = idx[0];
    req_op[3*idx +: 3] = op; req_a[8*idx +: 8] = a; req_b[8*idx +: 8] = b;
    req_valid = er; rsp_ready = 1'b0; #1;
    n_vec++;
    if (req_ready !== er) begin n_err++; $display("FAIL %s grant: got %b want %b", nm, req_ready, er); end
    for (int k = 1; k <= lat; k++) begin
      step();
      if (k == 1) begin req_valid = 2'b00; #1; end
      n_vec++;
      if (k < lat) begin
        if ({rsp_valid, req_ready, alu_op, alu_a, alu_b} !== {1'b0, 2'b00, op, a, b}) begin
          n_err++;
          $display("FAIL %s exec T+%0d: got v=%b rdy=%b alu=%h/%h/%h want v=0 rdy=00 alu=%h/%h/%h",
                   nm, k, rsp_valid, req_ready, alu_op, alu_a, alu_b, op, a, b);
        end
      end else begin
        if ({rsp_valid, rsp_id, rsp_s, rsp_flag & chk_f, rsp_err} !== {1'b1, id, es, ef & chk_f, ee}) begin
          n_err++;
          $display("FAIL %s rsp T+%0d: got v=%b id=%b s=%h f=%b e=%b want v=1 id=%b s=%h f=%b e=%b",
                   nm, k, rsp_valid, rsp_id, rsp_s, rsp_flag, rsp_err, id, es, ef, ee);
        end
      end
    end
    rsp_ready = 1'b1;
    step(); rsp_ready = 1'b0; #1;
    n_vec++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL %s handshake: rsp_valid got %b want 0", nm, rsp_valid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    req_op = '0; req_a = '0; req_b = '0;
    #1;
    n_vec++;
    if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset ready: got %b want 00", req_ready); end
    n_vec++;
    if ({alu_op, alu_a, alu_b} !== 19'h0) begin
      n_err++; $display("FAIL reset alu: got %h/%h/%h want 0/00/00", alu_op, alu_a, alu_b);
    end
    n_vec++;
    if ({rsp_valid, rsp_id, rsp_s, rsp_flag, rsp_err} !== 12'h0) begin
      n_err++; $display("FAIL reset rsp: got v=%b id=%b s=%h f=%b e=%b want all 0", rsp_valid, rsp_id, rsp_s, rsp_flag, rsp_err);
    end
    step(); step();
    req_valid = 2'b00; rsp_ready = 1'b0; rst_n = 1'b1; #1;
  endtask

  task automatic test_soma();
    do_op(0, 3'b000, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b1, 1'b0, 4, "soma");
  endtask

  task automatic test_carry_sub();
    do_op(1, 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 4, "carry");
    do_op(1, 3'b001, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 4, "sub");
  endtask

  task automatic test_badop();
    if (OPCHK) do_op(0, 3'b101, 8'h3C, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b1, 1, "badop");
    else       do_op(0, 3'b101, 8'h3C, 8'h0F, 8'h33, 1'b0, 1'b1, 1'b0, 4, "badop");
  endtask

  task automatic test_back_to_back();
    logic [1:0] g [4];
    logic [1:0] ge [4];
    int ng = 0;
    int c  = 0;
    ge[0] = 2'b01; ge[1] = 2'b10; ge[2] = 2'b01; ge[3] = 2'b10;
    do_reset();
    req_op = {3'b000, 3'b000}; req_a = 16'h0102; req_b = 16'h0304;
    req_valid = 2'b11; rsp_ready = 1'b1; #1;
    while (ng < 4 && c < 40) begin
      n_vec++;
      if (req_ready === 2'b11) begin n_err++; $display("FAIL rr onehot: got %b want not 11", req_ready); end
      if (req_ready !== 2'b00) begin g[ng] = req_ready; ng++; end
      step(); c++;
    end
    n_vec++;
    if (ng !== 4) begin n_err++; $display("FAIL rr count: got %0d grants want 4", ng); end
    for (int i = 0; i < ng; i++) begin
      n_vec++;
      if (g[i] !== ge[i]) begin n_err++; $display("FAIL rr grant%0d: got %b want %b", i, g[i], ge[i]); end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int c = 0;
    req_op = {3'b001, 3'b000}; req_a = 16'h0920; req_b = 16'h0122;
    req_valid = 2'b01; rsp_ready = 1'b0; #1;
    n_vec++;
    if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp grant: got %b want 01", req_ready); end
    step(); req_valid = 2'b10; #1;
    while (!rsp_valid && c < 10) begin step(); c++; end
    n_vec++;
    if (c !== 3) begin n_err++; $display("FAIL bp latency: got %0d want 3 cycles after T+1", c); end
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_s, rsp_flag, req_ready} !== {1'b1, 1'b0, 8'h42, 1'b0, 2'b00}) begin
        n_err++;
        $display("FAIL bp hold%0d: got v=%b id=%b s=%h f=%b rdy=%b want v=1 id=0 s=42 f=0 rdy=00",
                 k, rsp_valid, rsp_id, rsp_s, rsp_flag, req_ready);
      end
      step();
    end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0; #1;
    n_vec++;
    if ({rsp_valid, req_ready} !== 3'b010) begin
      n_err++; $display("FAIL bp regrant: got v=%b rdy=%b want v=0 rdy=10", rsp_valid, req_ready);
    end
    step();
    drain();
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    req_op = {3'b000, 3'b000}; req_a = 16'h00AA; req_b = 16'h0011;
    req_valid = 2'b01; #1;
    step(); req_valid = 2'b00;
    step();
    rst_n = 1'b0; #1;
    n_vec++;
    if ({req_ready, alu_op, alu_a, alu_b} !== 21'h0) begin
      n_err++; $display("FAIL rstmid alu: got rdy=%b alu=%h/%h/%h want all 0", req_ready, alu_op, alu_a, alu_b);
    end
    n_vec++;
    if ({rsp_valid, rsp_id, rsp_s, rsp_flag, rsp_err} !== 12'h0) begin
      n_err++; $display("FAIL rstmid rsp: got v=%b s=%h want v=0 s=00", rsp_valid, rsp_s);
    end
    step(); step();
    rst_n = 1'b1; #1;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid !== 1'b0) seen = 1'b1;
      step();
    end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL rstmid ghost: got rsp_valid=1 want 0 after release"); end
    req_valid = 2'b11; #1;
    n_vec++;
    if (req_ready !== 2'b01) begin n_err++; $display("FAIL rstmid ptr: got %b want 01", req_ready); end
    step();
    drain();
  endtask

  initial begin
    test_reset();
    test_soma();
    test_carry_sub();
    test_badop();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ula_arbitro.md
ULA_ARBITRO -- requirements
Module: ula_arbitro

Interface
REQ-001 SHALL have parameter: ALU_LAT, default 2, count of register stages in the shared ALU between operand input and result output.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  in  2  bit i = requester i presents an operation.
REQ-005 SHALL have port: req_ready  out  2  bit i = requester i's operation accepted this cycle.
REQ-006 SHALL have port: req_op  in  6  opcode of requester i in bits [3i+2:3i].
REQ-007 SHALL have port: req_a  in  16  operand A of requester i in bits [8i+7:8i].
REQ-008 SHALL have port: req_b  in  16  operand B of requester i in bits [8i+7:8i].
REQ-009 SHALL have ports: alu_a  out  8; alu_b  out  8; alu_op  out  3. These are registered ALU operands and opcode.
REQ-010 SHALL have ports: alu_s  in  8; alu_flag  in  1. These are the ALU result and the carry flag (meaningful for opcode 000).
REQ-011 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1. These form the response handshake.
REQ-012 SHALL have ports: rsp_id  out  1; rsp_s  out  8; rsp_flag  out  1; rsp_err  out  1. These are the response payload.

Function
REQ-013 SHALL use FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-014 SHALL, in IDLE, when any req_valid is set, grant one requester: assert its req_ready for exactly that cycle (T), register its op/a/b onto alu_*, latch its index for rsp_id, and enter EXEC.
REQ-015 SHALL arbitrate round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of pointer.
REQ-016 SHALL never assert req_ready outside IDLE, nor more than one bit at once.
REQ-017 SHALL hold alu_a/alu_b/alu_op stable for all of EXEC, which lasts ALU_LAT+1 cycles (T+1 .. T+ALU_LAT+1).
REQ-018 SHALL load rsp_s=alu_s, rsp_flag=alu_flag, rsp_err=0 at the closing edge of the last EXEC cycle and enter RESP; rsp_valid is high from T+ALU_LAT+2 (T+4 at default).
REQ-019 SHALL, in RESP, hold rsp_valid and payload stable until rsp_ready=1; on that handshake, drop rsp_valid and return to IDLE (next grant possible the following cycle).
REQ-020 SHALL ignore rsp_ready outside RESP.
REQ-021 SHALL leave alu_* unchanged in IDLE/RESP (hold last values).

Reset
REQ-022 SHALL, on rst_n low, immediately clear: state=IDLE, req_ready=0, alu_a/alu_b/alu_op=0, rsp_valid/rsp_id/rsp_s/rsp_flag/rsp_err=0, round-robin pointer such that requester 0 wins the first contested grant.
REQ-023 SHALL discard any in-flight operation on reset mid-EXEC or mid-RESP; no response is produced for it.

Configuration
REQ-024 SHALL support macro ULA_ARBITRO_OPCHECK_EN.
REQ-025 SHALL, with ULA_ARBITRO_OPCHECK_EN defined, accept an opcode other than 000/001 normally but skip EXEC: enter RESP at T+1 with rsp_err=1, rsp_s=0, rsp_flag=0, alu_* unchanged.
REQ-026 SHALL, without ULA_ARBITRO_OPCHECK_EN, forward every opcode to the ALU per REQ-017/018 and tie rsp_err to 0 (port kept).

Structure
REQ-027 SHALL place opcode constants (OP_SOMA=3'b000, OP_SUB=3'b001), FSM state encoding and the ALU_LAT default in shared package ula_pkg.
REQ-028 SHALL implement arbitration in a sub-module arb_rr2 (2-way round-robin, grant-enable input, one-hot grant output).

Verification
REQ-029 SHALL cover: req0 op=000 a=0x0F b=0x01 at T -> rsp_valid at T+4, rsp_id=0, rsp_s=0x10, rsp_flag=0.
REQ-030 SHALL cover: req1 op=000 a=0xFF b=0x01 -> rsp_id=1, rsp_s=0x00, rsp_flag=1; op=001 a=0x05 b=0x07 -> rsp_s=0xFE.
REQ-031 SHALL cover: both valid continuously after reset, rsp_ready=1 -> grants 0,1,0,1; never both req_ready bits set.
REQ-032 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> payload stable, req_ready stays 0, grant only after handshake.
REQ-033 SHALL cover: op=3'b101 -> macro defined: rsp_err=1 at T+1, rsp_s=0; macro undefined: normal T+4 response, rsp_err=0.
REQ-034 SHALL cover: rst_n low at T+2 of an operation -> all outputs 0 at once, no rsp_valid after release, next contested grant goes to requester 0.
